tv_recorder: RTL and testbench
==============================

# tv_recorder

Synthesizable test-vector recorder: the write-side counterpart of our file-driven vector benches. It sits beside a DUT and captures one `{inputs, output}` word per strobe into an internal buffer. It also compares each word against an expected value and counts mismatches. After capture, it streams the buffer back out over a valid/ready port so a bench, or a later readback block, can rebuild a vector file.

## Interface
Parameters:
- WIDTH, 4, bits per captured word (e.g. `{a,b,c,y}`)
- DEPTH, 16, buffer entries; power of two, ≥ 2
- AW, $clog2(DEPTH), derived address width; not overridden

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a capture session; sampled only in IDLE
- stop  in  1  end capture and begin dump; sampled only in CAPTURE
- sample_valid  in  1  capture strobe
- sample_data  in  WIDTH  observed word
- expect_data  in  WIDTH  expected word for the same strobe
- out_valid  out  1  dump word available
- out_ready  in  1  consumer accepts dump word
- out_data  out  WIDTH  dump word
- out_last  out  1  marks the final dump word
- done  out  1  one-cycle pulse when the session ends
- busy  out  1  state ≠ IDLE
- count  out  AW+1  words stored, 0..DEPTH
- errors  out  AW+1  mismatches among stored words
- overflow  out  1  sticky; a strobe arrived while the buffer was full

## Operation
- The state machine has three states: IDLE, CAPTURE and DUMP.
- IDLE:
  - start=1 → CAPTURE next cycle.
  - On that same edge, count, errors, overflow, wr_ptr and rd_ptr clear to 0.
  - stop, sample_valid and out_ready are ignored.
- CAPTURE, sample_valid=1 with count<DEPTH:
  - mem[wr_ptr] ← sample_data.
  - wr_ptr increments; count increments.
  - If sample_data !== expect_data, errors increments.
- CAPTURE, sample_valid=1 with count==DEPTH:
  - The word is dropped and not compared.
  - overflow ← 1.
- CAPTURE, stop=1:
  - Next state is DUMP.
  - A sample_valid in the same cycle is still processed under the rules above.
  - start is ignored.
- DUMP:
  - out_valid=1 while rd_ptr<count.
  - out_data = mem[rd_ptr].
  - out_last = (rd_ptr==count-1).
  - A handshake (out_valid & out_ready) increments rd_ptr.
  - A handshake with out_last=1 → IDLE, and done=1 in the following cycle.
- DUMP entered with count==0:
  - out_valid stays 0.
  - Next state is IDLE, with done pulsed on that IDLE cycle.
- The results count, errors and overflow hold their values in IDLE until the next start.
- Buffer contents are not cleared by start or reset.
- Arithmetic widths:
  - count and errors are AW+1 bits wide and never exceed DEPTH, so they need no saturation logic.
  - wr_ptr and rd_ptr are AW bits wide; wr_ptr wraps from DEPTH-1 to 0 but stops advancing once count==DEPTH.

## Timing
- Reset (reset=0 at a rising edge):
  - state=IDLE.
  - out_valid=0, out_last=0, done=0, busy=0.
  - count=0, errors=0, overflow=0, out_data=0.
  - Reset applies from any state, including mid-CAPTURE or mid-DUMP. The dump is abandoned with no done pulse.
- Capture latency: a strobe on edge N is reflected in count and errors after edge N.
- Dump timing:
  - The first out_valid appears the cycle after the stop edge.
  - Throughput is 1 word/cycle when out_ready is held at 1.
- out_data and out_last stay stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake.
- done is high for exactly one cycle; busy is already 0 in that cycle.

## Test plan
- Eight-vector session: start, then strobe the sillyfunction truth table (0001, 0010, 0100, 0110, 1001, 1011, 1100, 1110) with expect equal to sample, then stop.
  - Required: count=8, errors=0.
  - Dump returns the same 8 words in order, with out_last on 1110.
  - done pulses once.
- Mismatch counting: same session, but expect differs on words 2 and 5 (y bit flipped).
  - Required: errors=2, count=8; dumped data equals the sample values.
- Overflow (DEPTH=16): send 18 strobes, two of them mismatching after the buffer is full.
  - Required: count=16, overflow=1; errors exclude the dropped words.
  - Dump yields 16 words.
- Backpressure: during dump, toggle out_ready 1,0,0,1,0,1…
  - Required: out_data and out_last hold during stalls; no word is lost or repeated.
- Empty session and simultaneous stop+sample:
  - start then immediate stop → no out_valid; done one cycle after DUMP.
  - stop together with sample_valid → that word is stored and dumped last.
- Reset mid-dump: assert reset=0 after 3 handshakes.
  - Required: all outputs return to reset values next cycle, no done pulse.
  - A new start produces a clean session with count restarting at 0.

Source files
------------

// File: rtl/tv_recorder.sv
// Test-vector recorder: captures {inputs,output} words per strobe, counts
// mismatches against an expected word, then streams the buffer out.
module tv_recorder #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample_data,
    input  logic [WIDTH-1:0] expect_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             done,
    output logic             busy,
    output logic [AW:0]      count,
    output logic [AW:0]      errors,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DUMP
    } state_t;

    localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PONE  = AW'(1);

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic            full;
    logic            accept;
    logic            handshake;

    assign full      = (count == FULL);
    assign accept    = (state == CAPTURE) && sample_valid && !full;
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (stop) state_nxt = DUMP;
            end
            DUMP: begin
                // An empty buffer has nothing to stream, so the session ends at once.
                if (count == '0) state_nxt = IDLE;
                else if (handshake && out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = (state != IDLE);
        if (state == DUMP && {1'b0, rd_ptr} < count) begin
            out_valid = 1'b1;
            out_data  = mem[rd_ptr];
            out_last  = ({1'b0, rd_ptr} == count - CONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count    <= '0;
            errors   <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == DUMP) && (state_nxt == IDLE);
            if (state == IDLE && start) begin
                count    <= '0;
                errors   <= '0;
                overflow <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + PONE;
                count  <= count + CONE;
                if (sample_data != expect_data) errors <= errors + CONE;
            end
            // Dropped words are neither stored nor compared.
            if (state == CAPTURE && sample_valid && full) overflow <= 1'b1;
            if (handshake) rd_ptr <= rd_ptr + PONE;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= sample_data;
    end

endmodule

// File: tb/tb_tv_recorder.sv
// Scoreboard bench for tv_recorder: stimulus queues expected dump words,
// a negedge monitor pops and compares them on every handshake.
module tb_tv_recorder;

    localparam int W = 4;
    localparam int D = 16;
    localparam int AW = $clog2(D);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic          sample_valid;
    logic [W-1:0]  sample_data;
    logic [W-1:0]  expect_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          done;
    logic          busy;
    logic [AW:0]   count;
    logic [AW:0]   errors;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [W:0]   sb_q[$];
    logic [W-1:0] stored[$];
    bit           pat[6] = '{1, 0, 0, 1, 0, 1};
    logic [W-1:0] tt[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0110,
                            4'b1001, 4'b1011, 4'b1100, 4'b1110};

    logic         stall_prev = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;

    always #5 clk = ~clk;

    tv_recorder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .sample_valid(sample_valid),
        .sample_data(sample_data),
        .expect_data(expect_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .done(done),
        .busy(busy),
        .count(count),
        .errors(errors),
        .overflow(overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops on handshakes, plus stall stability.
    always @(negedge clk) begin
        logic [W:0] e;
        if (stall_prev) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), int'(prev_data));
            chk("hold_last", int'(out_last), int'(prev_last));
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_word", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("dump_data", int'(out_data), int'(e[W-1:0]));
                chk("dump_last", int'(out_last), int'(e[W]));
            end
        end
        stall_prev = out_valid && !out_ready && reset;
        prev_data  = out_data;
        prev_last  = out_last;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [W-1:0] s, input logic [W-1:0] e,
                          input logic st);
        sample_valid = 1'b1;
        sample_data  = s;
        expect_data  = e;
        stop         = st;
        tick();
        sample_valid = 1'b0;
        stop         = 1'b0;
        if (stored.size() < D) stored.push_back(s);
    endtask

    task automatic begin_session;
        stored.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_count", int'(count), 0);
        chk("start_errors", int'(errors), 0);
        chk("start_ovf", int'(overflow), 0);
    endtask

    task automatic end_session(input int mode, input int ec, input int ee,
                               input int eo, input bit stopped);
        int i;
        for (int k = 0; k < stored.size(); k++)
            sb_q.push_back({k == stored.size() - 1, stored[k]});
        if (!stopped) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        chk("cap_count", int'(count), ec);
        chk("cap_errors", int'(errors), ee);
        chk("cap_ovf", int'(overflow), eo);
        chk("first_valid", int'(out_valid), int'(ec != 0));
        for (i = 0; i < 200; i++) begin
            out_ready = (mode != 0) ? pat[i % 6] : 1'b1;
            tick();
            if (done) break;
        end
        out_ready = 1'b0;
        chk("done_seen", int'(done), 1);
        chk("done_busy", int'(busy), 0);
        chk("sb_drained", sb_q.size(), 0);
        if (mode == 0) chk("throughput", i, (ec > 0) ? ec - 1 : 0);
        tick();
        chk("done_pulse", int'(done), 0);
        chk("hold_count", int'(count), ec);
        chk("hold_errors", int'(errors), ee);
        chk("hold_ovf", int'(overflow), eo);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        sample_valid = 1'b0;
        sample_data = '0;
        expect_data = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_errors", int'(errors), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_data", int'(out_data), 0);
        reset = 1'b1;
        tick();

        // Truth-table session, all matching.
        begin_session();
        for (int k = 0; k < 8; k++) strobe(tt[k], tt[k], 1'b0);
        end_session(0, 8, 0, 0, 1'b0);

        // Strobes in IDLE are ignored.
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("idle_ignore", int'(count), 8);

        // Mismatches on words 2 and 5.
        begin_session();
        for (int k = 0; k < 8; k++)
            strobe(tt[k], (k == 2 || k == 5) ? tt[k] ^ 4'b0001 : tt[k], 1'b0);
        end_session(0, 8, 2, 0, 1'b0);

        // Overflow: 18 strobes, one kept mismatch, two dropped mismatches.
        begin_session();
        for (int k = 0; k < 18; k++) begin
            logic [W-1:0] s;
            s = W'(k);
            if (k >= 16) strobe(s, ~s, 1'b0);
            else strobe(s, (k == 3) ? s ^ 4'b0001 : s, 1'b0);
        end
        end_session(0, 16, 1, 1, 1'b0);

        // Backpressure with ready pattern 1,0,0,1,0,1.
        begin_session();
        for (int k = 0; k < 8; k++) strobe(tt[7-k], tt[7-k], 1'b0);
        end_session(1, 8, 0, 0, 1'b0);

        // Empty session.
        begin_session();
        end_session(0, 0, 0, 0, 1'b0);

        // Stop together with a sample.
        begin_session();
        strobe(4'b0011, 4'b0011, 1'b0);
        strobe(4'b0101, 4'b0101, 1'b0);
        strobe(4'b1111, 4'b1111, 1'b1);
        end_session(0, 3, 0, 0, 1'b1);

        // Reset after three dump handshakes.
        begin_session();
        for (int k = 0; k < 8; k++) strobe(tt[k], tt[k], 1'b0);
        for (int k = 0; k < stored.size(); k++)
            sb_q.push_back({k == stored.size() - 1, stored[k]});
        stop = 1'b1;
        tick();
        stop = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_rst_sb", sb_q.size(), 5);
        reset = 1'b0;
        out_ready = 1'b0;
        sb_q.delete();
        tick();
        chk("mrst_valid", int'(out_valid), 0);
        chk("mrst_last", int'(out_last), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_count", int'(count), 0);
        chk("mrst_errors", int'(errors), 0);
        chk("mrst_data", int'(out_data), 0);
        reset = 1'b1;
        tick();
        chk("mrst_nodone", int'(done), 0);
        begin_session();
        strobe(4'b1010, 4'b1010, 1'b0);
        chk("new_count", int'(count), 1);
        strobe(4'b0110, 4'b0111, 1'b0);
        end_session(0, 2, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
